// File: rtl/timer_irq_ctrl.sv
// Latches timer interrupt edges as pending bits and presents one fixed-priority request at a time to the CPU.
// Rise to pending in 1 cycle, pending to io_irqReq in 1 more; the request holds until io_irqAck.
module timer_irq_ctrl #(
   parameter int N_IRQ = 4,
   parameter int ID_W  = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_IRQ-1:0] io_irqIn,
   input  logic [N_IRQ-1:0] io_irqMask,
   output logic             io_irqReq,
   output logic [ID_W-1:0]  io_irqId,
   input  logic             io_irqAck,
   output logic [N_IRQ-1:0] io_pending,
   output logic [CNT_W-1:0] io_missCount,
   input  logic             io_missClear
);

   typedef enum logic {IDLE, REQ} state_t;

   state_t             state_q, state_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [N_IRQ-1:0]   prev_q;
   logic [N_IRQ-1:0]   pending_q, pending_d;
   logic [CNT_W-1:0]   miss_q, miss_d;

   logic [N_IRQ-1:0]   rise;
   logic [N_IRQ-1:0]   ack_clr;
   logic [N_IRQ-1:0]   cand;
   logic [ID_W-1:0]    id_pick;
   logic               miss_hit;

   assign rise = io_irqIn & ~prev_q;
   assign cand = pending_q & ~io_irqMask;

   always_comb begin
      ack_clr = '0;
      if (state_q == REQ && io_irqAck) begin
         ack_clr[id_q] = 1'b1;
      end
   end

   // Descending scan so the last hit, i.e. the lowest index, wins.
   always_comb begin
      id_pick = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (cand[i]) begin
            id_pick = ID_W'(i);
         end
      end
   end

   // A rise on a bit being acked in the same cycle re-arms it and is not a loss.
   assign miss_hit  = |(rise & pending_q & ~ack_clr);
   assign pending_d = rise | (pending_q & ~ack_clr);

   always_comb begin
      miss_d = miss_q;
      if (io_missClear) begin
         miss_d = miss_hit ? CNT_W'(1) : '0;
      end else if (miss_hit && miss_q != '1) begin
         miss_d = miss_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      case (state_q)
         IDLE: begin
            if (|cand) begin
               state_d = REQ;
               id_d    = id_pick;
            end
         end
         REQ: begin
            if (io_irqAck) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         id_q      <= '0;
         prev_q    <= '0;
         pending_q <= '0;
         miss_q    <= '0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         prev_q    <= io_irqIn;
         pending_q <= pending_d;
         miss_q    <= miss_d;
      end
   end

   assign io_irqReq    = (state_q == REQ);
   assign io_irqId     = id_q;
   assign io_pending   = pending_q;
   assign io_missCount = miss_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Bench for timer_irq_ctrl: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a behavioural model.
module tb_timer_irq_ctrl;

   localparam int N = 4;
   localparam int W = 2;
   localparam int C = 8;
   localparam int CMAX = (1 << C) - 1;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [N-1:0] irq_in = '0;
   logic [N-1:0] irq_mask = '0;
   logic         irq_ack = 1'b0;
   logic         miss_clear = 1'b0;
   logic         irq_req;
   logic [W-1:0] irq_id;
   logic [N-1:0] pending;
   logic [C-1:0] miss_count;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   timer_irq_ctrl #(.N_IRQ(N), .ID_W(W), .CNT_W(C)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .io_irqIn(irq_in),
      .io_irqMask(irq_mask),
      .io_irqReq(irq_req),
      .io_irqId(irq_id),
      .io_irqAck(irq_ack),
      .io_pending(pending),
      .io_missCount(miss_count),
      .io_missClear(miss_clear)
   );

   always #5 clk = ~clk;

   // Behavioural model: one line per interrupt, integer counter clamped at CMAX.
   bit m_prev [N] = '{default: 1'b0};
   bit m_pend [N] = '{default: 1'b0};
   int m_miss = 0;
   bit m_req  = 1'b0;
   int m_id   = 0;

   bit t_rise [N];
   bit t_lost;
   int t_cleared;
   int t_pick;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_prev <= '{default: 1'b0};
         m_pend <= '{default: 1'b0};
         m_miss <= 0;
         m_req  <= 1'b0;
         m_id   <= 0;
      end else begin
         t_cleared = (m_req && irq_ack) ? m_id : -1;
         t_lost = 1'b0;
         for (int i = 0; i < N; i++) begin
            t_rise[i] = irq_in[i] && !m_prev[i];
            if (t_rise[i] && m_pend[i] && i != t_cleared) t_lost = 1'b1;
         end
         for (int i = 0; i < N; i++) begin
            m_prev[i] <= irq_in[i];
            if (t_rise[i])          m_pend[i] <= 1'b1;
            else if (i == t_cleared) m_pend[i] <= 1'b0;
         end
         if (miss_clear)  m_miss <= t_lost ? 1 : 0;
         else if (t_lost) m_miss <= (m_miss + 1 > CMAX) ? CMAX : m_miss + 1;
         if (!m_req) begin
            t_pick = -1;
            for (int i = N - 1; i >= 0; i--)
               if (m_pend[i] && !irq_mask[i]) t_pick = i;
            if (t_pick >= 0) begin
               m_req <= 1'b1;
               m_id  <= t_pick;
            end
         end else if (irq_ack) begin
            m_req <= 1'b0;
         end
      end
   end

   function automatic logic [N-1:0] model_pend();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en && reset_n) begin
         chk("model req", 32'(irq_req), 32'(m_req));
         if (m_req) chk("model id", 32'(irq_id), 32'(m_id));
         chk("model pending", 32'(pending), 32'(model_pend()));
         chk("model miss", 32'(miss_count), 32'(m_miss));
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      step(2);
      chk("reset req", 32'(irq_req), 32'd0);
      chk("reset id", 32'(irq_id), 32'd0);
      chk("reset pending", 32'(pending), 32'd0);
      chk("reset miss", 32'(miss_count), 32'd0);
      reset_n = 1'b1;
      chk_en  = 1'b1;
      step();

      // single rise, ack
      irq_in = 4'b0001; step(); irq_in = '0;
      chk("t1 pending", 32'(pending), 32'b0001);
      chk("t1 req early", 32'(irq_req), 32'd0);
      step();
      chk("t1 req", 32'(irq_req), 32'd1);
      chk("t1 id", 32'(irq_id), 32'd0);
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
      chk("t1 req after ack", 32'(irq_req), 32'd0);
      chk("t1 pending after ack", 32'(pending), 32'd0);

      // two simultaneous rises, priority and gap
      irq_in = 4'b1010; step(); irq_in = '0; step();
      chk("t2 id first", 32'(irq_id), 32'd1);
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
      chk("t2 gap", 32'(irq_req), 32'd0);
      chk("t2 pending mid", 32'(pending), 32'b1000);
      step();
      chk("t2 req second", 32'(irq_req), 32'd1);
      chk("t2 id second", 32'(irq_id), 32'd3);
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
      chk("t2 pending end", 32'(pending), 32'd0);

      // misses on an unacked bit, clear coinciding with a miss
      irq_in = 4'b0100; step(); irq_in = '0; step();
      irq_in = 4'b0100; step(); irq_in = '0; step();
      irq_in = 4'b0100; step(); irq_in = '0;
      chk("t3 miss", 32'(miss_count), 32'd2);
      chk("t3 pending", 32'(pending), 32'b0100);
      step();
      irq_in = 4'b0100; miss_clear = 1'b1; step(); irq_in = '0; miss_clear = 1'b0;
      chk("t3 clear+miss", 32'(miss_count), 32'd1);
      irq_ack = 1'b1; step(); irq_ack = 1'b0; step();

      // masked bit stays pending, unmask requests without a new edge
      irq_mask = 4'b0001; irq_in = 4'b0001; step(); irq_in = '0;
      chk("t4 pending", 32'(pending), 32'b0001);
      step(2);
      chk("t4 masked req", 32'(irq_req), 32'd0);
      irq_mask = '0; step();
      chk("t4 unmask req", 32'(irq_req), 32'd1);
      chk("t4 unmask id", 32'(irq_id), 32'd0);
      irq_ack = 1'b1; step(); irq_ack = 1'b0; step();

      // rise on the acked bit in the ack cycle
      irq_in = 4'b0001; step(); irq_in = '0; step();
      irq_ack = 1'b1; irq_in = 4'b0001; step(); irq_ack = 1'b0; irq_in = '0;
      chk("t5 req gap", 32'(irq_req), 32'd0);
      chk("t5 pending kept", 32'(pending), 32'b0001);
      chk("t5 miss unchanged", 32'(miss_count), 32'd1);
      step();
      chk("t5 req again", 32'(irq_req), 32'd1);
      irq_ack = 1'b1; step(); irq_ack = 1'b0; step();

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         irq_in     = N'($urandom_range(0, (1 << N) - 1));
         irq_ack    = ($urandom_range(0, 3) == 0);
         miss_clear = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 7) == 0) irq_mask = N'($urandom_range(0, (1 << N) - 1));
         step();
      end
      irq_in = '0; irq_ack = 1'b0; miss_clear = 1'b0; irq_mask = '0;
      step();

      // saturation, then async reset mid-request
      for (int k = 0; k < 300; k++) begin
         irq_in = 4'b0100; step(); irq_in = '0; step();
      end
      chk("t6 saturated", 32'(miss_count), 32'(CMAX));
      chk("t6 in req", 32'(irq_req), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("t6 async req", 32'(irq_req), 32'd0);
      chk("t6 async pending", 32'(pending), 32'd0);
      chk("t6 async miss", 32'(miss_count), 32'd0);

      // a line high at reset release counts as a rise
      irq_in = 4'b0010;
      step();
      reset_n = 1'b1;
      step();
      chk("release rise", 32'(pending), 32'b0010);
      irq_in = '0;
      step(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
